// File: rtl/fn1_dot_pkg.sv
// fn1_dot_pkg: shared widths, pipeline depth and tag type for the fn1 dot-product stage.
package fn1_dot_pkg;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 16;
  localparam int MUL_STAGES = 3;
  localparam int OP_W       = 16;
  localparam int PROD_W     = 2 * OP_W;
  typedef struct packed {
    logic v;
    logic last;
  } tag_t;
endpackage

// File: rtl/fn1_dot_mul.sv
// fn1_dot_mul: 3-register signed multiplier (input regs, product reg, output reg) with clock enable.
module fn1_dot_mul
  import fn1_dot_pkg::*;
(
  input  logic                     clk,
  input  logic                     ce_i,
  input  logic signed [OP_W-1:0]   a_i,
  input  logic signed [OP_W-1:0]   b_i,
  output logic signed [PROD_W-1:0] p_o
);
  logic signed [OP_W-1:0]   a_q, b_q;
  logic signed [PROD_W-1:0] m_q, p_q;
  // Data path carries no reset; the tag pipeline in the parent marks which stages are live.
  always_ff @(posedge clk) begin
    if (ce_i) begin
      a_q <= a_i;
      b_q <= b_i;
      m_q <= a_q * b_q;
      p_q <= m_q;
    end
  end
  assign p_o = p_q;
endmodule

// File: rtl/fn1_dot_acc.sv
// fn1_dot_acc: streaming signed dot product; accumulates per-frame products and emits one sum per frame.
module fn1_dot_acc
  import fn1_dot_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);
  tag_t [MUL_STAGES-1:0]   tag_q, tag_d;
  tag_t                    tag_in;
  logic [ACC_W-1:0]        acc_q, acc_d, sum, p_ext;
  logic [CNT_W-1:0]        cnt_q, cnt_d, out_count_q, out_count_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic                    first_q, first_d, out_valid_q, out_valid_d;
  logic                    adv, fire, done;
  logic signed [PROD_W-1:0] p;

  fn1_dot_mul u_mul (
    .clk  (clk),
    .ce_i (adv),
    .a_i  (in_a),
    .b_i  (in_b),
    .p_o  (p)
  );

  assign tag_in = '{v: in_valid, last: in_valid && in_last};
  assign p_ext  = ACC_W'(p);

  // A held, unaccepted result freezes the multiplier and tags together so they stay aligned.
  always_comb begin
    adv         = !out_valid_q || out_ready;
    tag_d       = adv ? {tag_q[MUL_STAGES-2:0], tag_in} : tag_q;
    fire        = adv && tag_q[MUL_STAGES-1].v;
    done        = fire && tag_q[MUL_STAGES-1].last;
    sum         = (first_q ? '0 : acc_q) + p_ext;
    acc_d       = fire ? (done ? '0 : sum) : acc_q;
    cnt_d       = fire ? (done ? '0 : cnt_q + 1'b1) : cnt_q;
    first_d     = fire ? done : first_q;
    out_valid_d = done || (out_valid_q && !out_ready);
    out_data_d  = done ? sum : out_data_q;
    out_count_d = done ? cnt_q + 1'b1 : out_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
endmodule
